reorder_buffer: RTL and testbench

REORDER_BUFFER -- requirements
Module: reorder_buffer

---
 rtl/reorder_buffer_pkg.sv | 25 ++
 rtl/reorder_buffer.sv | 178 +++++++++++++++++
 tb/tb_reorder_buffer.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/reorder_buffer_pkg.sv
// ----------------------------------------------------------------------------
// reorder_buffer_pkg
// Shared definitions for the reorder buffer: sizing constants and the
// common-data-bus broadcast type. Every file that needs these imports
// this package instead of redefining them.
//   ROB_WIDTH  : tag/pointer width, the buffer holds 2**ROB_WIDTH entries
//   REG_WIDTH  : architectural register index width
//   cdb_t      : one result broadcast {valid, tag, data}
// ----------------------------------------------------------------------------
package reorder_buffer_pkg;

   localparam int ROB_WIDTH  = 3;
   localparam int REG_WIDTH  = 5;
   localparam int DATA_WIDTH = 32;
   localparam int ROB_DEPTH  = 2 ** ROB_WIDTH;

   localparam logic [ROB_WIDTH:0] ROB_FULL = (ROB_WIDTH + 1)'(ROB_DEPTH);

   typedef struct packed {
      logic                  valid;
      logic [ROB_WIDTH-1:0]  tag;
      logic [DATA_WIDTH-1:0] data;
   } cdb_t;

endpackage

// File: rtl/reorder_buffer.sv
// ----------------------------------------------------------------------------
// reorder_buffer
// In-order retirement buffer for an out-of-order core. Instructions are
// allocated at the tail in program order, results arrive out of order on
// the common data bus, and the head entry retires once its result is in.
// Two operand read ports look up a tag, bypassing a same-cycle broadcast.
//
// Ports
//   clk              rising-edge clock
//   reset_n          synchronous active-low reset
//   issue_req        allocate one entry this cycle
//   issue_arch_num   destination register of the issuing instruction
//   issue_ready      buffer not full, allocation accepted
//   issue_tag        tag the next allocation receives (tail pointer)
//   cdb_valid/tag/data  result broadcast
//   read_tag[1:0]    operand tags to look up
//   read_valid[1:0]  operand value available
//   read_data[1:0]   operand value
//   commit           head entry retires this cycle
//   commit_arch_num  retiring destination register
//   commit_tag       retiring tag (head pointer)
//   commit_data      retiring result
//   flush            discard all in-flight entries
// ----------------------------------------------------------------------------
module reorder_buffer
   import reorder_buffer_pkg::*;
(
   input  logic                            clk,
   input  logic                            reset_n,
   input  logic                            issue_req,
   input  logic [REG_WIDTH-1:0]            issue_arch_num,
   output logic                            issue_ready,
   output logic [ROB_WIDTH-1:0]            issue_tag,
   input  logic                            cdb_valid,
   input  logic [ROB_WIDTH-1:0]            cdb_tag,
   input  logic [DATA_WIDTH-1:0]           cdb_data,
   input  logic [1:0][ROB_WIDTH-1:0]       read_tag,
   output logic [1:0]                      read_valid,
   output logic [1:0][DATA_WIDTH-1:0]      read_data,
   output logic                            commit,
   output logic [REG_WIDTH-1:0]            commit_arch_num,
   output logic [ROB_WIDTH-1:0]            commit_tag,
   output logic [DATA_WIDTH-1:0]           commit_data,
   input  logic                            flush
);

   cdb_t                  cdb;
   logic                  issueAccept;

   logic [ROB_WIDTH-1:0]  head_q, head_d;
   logic [ROB_WIDTH-1:0]  tail_q, tail_d;
   logic [ROB_WIDTH:0]    count_q, count_d;

   logic [ROB_DEPTH-1:0]  busyAll;
   logic [ROB_DEPTH-1:0]  doneAll;
   logic [REG_WIDTH-1:0]  archAll [ROB_DEPTH];
   logic [DATA_WIDTH-1:0] dataAll [ROB_DEPTH];

   assign cdb = '{valid: cdb_valid, tag: cdb_tag, data: cdb_data};

   // Fullness comes from registered count only, so a slot freed by a
   // commit in this cycle cannot be handed out until the next cycle.
   assign issue_ready = (count_q != ROB_FULL);
   assign issue_tag   = tail_q;
   assign issueAccept = issue_req && issue_ready;

   // Retirement looks only at stored state; a broadcast landing on the
   // head entry therefore retires one cycle later.
   assign commit          = busyAll[head_q] && doneAll[head_q];
   assign commit_tag      = head_q;
   assign commit_arch_num = archAll[head_q];
   assign commit_data     = dataAll[head_q];

   // Per-entry storage. Each entry owns its own registers; the packed
   // views above are just wiring so the muxes can index them.
   for (genvar i = 0; i < ROB_DEPTH; i++) begin : gEntry
      localparam logic [ROB_WIDTH-1:0] IDX = ROB_WIDTH'(i);

      logic                  busy_q, busy_d;
      logic                  done_q, done_d;
      logic [REG_WIDTH-1:0]  arch_q, arch_d;
      logic [DATA_WIDTH-1:0] data_q, data_d;

      assign busyAll[i] = busy_q;
      assign doneAll[i] = done_q;
      assign archAll[i] = arch_q;
      assign dataAll[i] = data_q;

      // Next state of one entry. Flush wins over everything. Otherwise a
      // broadcast fills a busy entry, a commit frees the head, and an
      // accepted issue claims the tail. Issue and commit never target the
      // same entry in one cycle: that would need the buffer both empty
      // (nothing to commit) and full (issue refused).
      always_comb begin
         busy_d = busy_q;
         done_d = done_q;
         arch_d = arch_q;
         data_d = data_q;
         if (flush) begin
            busy_d = 1'b0;
            done_d = 1'b0;
         end else begin
            if (cdb.valid && (cdb.tag == IDX) && busy_q) begin
               done_d = 1'b1;
               data_d = cdb.data;
            end
            if (commit && (head_q == IDX)) begin
               busy_d = 1'b0;
               done_d = 1'b0;
            end
            if (issueAccept && (tail_q == IDX)) begin
               busy_d = 1'b1;
               done_d = 1'b0;
               arch_d = issue_arch_num;
            end
         end
      end

      // Entry registers. Only the status bits need a reset value; the
      // payload is meaningless until the entry is marked busy and done.
      always_ff @(posedge clk) begin
         if (!reset_n) begin
            busy_q <= 1'b0;
            done_q <= 1'b0;
         end else begin
            busy_q <= busy_d;
            done_q <= done_d;
         end
         arch_q <= arch_d;
         data_q <= data_d;
      end
   end

   // Pointer and occupancy update. Pointers are exactly ROB_WIDTH bits so
   // the increment wraps from the last entry back to zero on its own.
   always_comb begin
      head_d  = head_q + ROB_WIDTH'(commit);
      tail_d  = tail_q + ROB_WIDTH'(issueAccept);
      count_d = count_q + (ROB_WIDTH + 1)'(issueAccept)
                        - (ROB_WIDTH + 1)'(commit);
      if (flush) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end
   end

   // Pointer registers.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   // Operand lookup. A broadcast to the requested tag in this very cycle
   // takes priority, then a completed stored result. An entry that is
   // retiring this cycle is still busy and done, so it still reads valid.
   always_comb begin
      read_valid = '0;
      read_data  = '0;
      for (int p = 0; p < 2; p++) begin
         if (cdb.valid && (cdb.tag == read_tag[p])) begin
            read_valid[p] = 1'b1;
            read_data[p]  = cdb.data;
         end else if (busyAll[read_tag[p]] && doneAll[read_tag[p]]) begin
            read_valid[p] = 1'b1;
            read_data[p]  = dataAll[read_tag[p]];
         end
      end
   end

endmodule

// File: tb/tb_reorder_buffer.sv
// ----------------------------------------------------------------------------
// tb_reorder_buffer
// Drives the reorder buffer with directed and random traffic and compares
// every output against a queue-based model of in-order retirement.
// ----------------------------------------------------------------------------
module tb_reorder_buffer;

   logic             clk;
   logic             reset_n;
   logic             issue_req;
   logic [4:0]       issue_arch_num;
   logic             issue_ready;
   logic [2:0]       issue_tag;
   logic             cdb_valid;
   logic [2:0]       cdb_tag;
   logic [31:0]      cdb_data;
   logic [1:0][2:0]  read_tag;
   logic [1:0]       read_valid;
   logic [1:0][31:0] read_data;
   logic             commit;
   logic [4:0]       commit_arch_num;
   logic [2:0]       commit_tag;
   logic [31:0]      commit_data;
   logic             flush;

   int testsRun    = 0;
   int testsFailed = 0;

   typedef struct {
      logic [2:0]  tag;
      logic [4:0]  arch;
      bit          done;
      logic [31:0] data;
   } robEntry_t;

   robEntry_t rob[$];
   int        tailTag = 0;

   reorder_buffer dut (
      .clk             (clk),
      .reset_n         (reset_n),
      .issue_req       (issue_req),
      .issue_arch_num  (issue_arch_num),
      .issue_ready     (issue_ready),
      .issue_tag       (issue_tag),
      .cdb_valid       (cdb_valid),
      .cdb_tag         (cdb_tag),
      .cdb_data        (cdb_data),
      .read_tag        (read_tag),
      .read_valid      (read_valid),
      .read_data       (read_data),
      .commit          (commit),
      .commit_arch_num (commit_arch_num),
      .commit_tag      (commit_tag),
      .commit_data     (commit_data),
      .flush           (flush)
   );

   // Free-running clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single comparison point: counts the check and reports a mismatch.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      testsRun++;
      if (observed !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t",
                  tag, observed, expected, $time);
      end
   endtask

   // One cycle: drive inputs just after an edge, check the combinational
   // outputs against the model, then advance the model across the edge.
   task automatic applyStimulus(input bit ir, input logic [4:0] an,
                                input bit cv, input logic [2:0] ct,
                                input logic [31:0] cd,
                                input logic [2:0] r0, input logic [2:0] r1,
                                input bit fl, input bit rn);
      bit          expReady;
      bit          expCommit;
      bit          expRv;
      logic [31:0] expRd;
      logic [2:0]  rt;
      robEntry_t   e;

      issue_req      = ir;
      issue_arch_num = an;
      cdb_valid      = cv;
      cdb_tag        = ct;
      cdb_data       = cd;
      read_tag[0]    = r0;
      read_tag[1]    = r1;
      flush          = fl;
      reset_n        = rn;
      #1;

      expReady  = (rob.size() != 8);
      expCommit = (rob.size() > 0) && rob[0].done;
      checkOutput("issue_ready", 32'(issue_ready), 32'(expReady));
      checkOutput("issue_tag", 32'(issue_tag), 32'(tailTag));
      checkOutput("commit", 32'(commit), 32'(expCommit));
      if (expCommit) begin
         checkOutput("commit_tag", 32'(commit_tag), 32'(rob[0].tag));
         checkOutput("commit_arch", 32'(commit_arch_num), 32'(rob[0].arch));
         checkOutput("commit_data", commit_data, rob[0].data);
      end
      for (int p = 0; p < 2; p++) begin
         rt    = (p == 0) ? r0 : r1;
         expRv = 1'b0;
         expRd = '0;
         if (cv && ct == rt) begin
            expRv = 1'b1;
            expRd = cd;
         end else begin
            foreach (rob[k]) begin
               if (rob[k].tag == rt && rob[k].done) begin
                  expRv = 1'b1;
                  expRd = rob[k].data;
               end
            end
         end
         checkOutput(p == 0 ? "read_valid0" : "read_valid1",
                     32'(read_valid[p]), 32'(expRv));
         if (expRv)
            checkOutput(p == 0 ? "read_data0" : "read_data1",
                        read_data[p], expRd);
      end

      @(posedge clk);
      if (!rn || fl) begin
         rob.delete();
         tailTag = 0;
      end else begin
         if (cv) begin
            foreach (rob[k]) begin
               if (rob[k].tag == ct) begin
                  rob[k].done = 1'b1;
                  rob[k].data = cd;
               end
            end
         end
         if (expCommit) void'(rob.pop_front());
         if (ir && expReady) begin
            e.tag  = 3'(tailTag);
            e.arch = an;
            e.done = 1'b0;
            e.data = '0;
            rob.push_back(e);
            tailTag = (tailTag + 1) % 8;
         end
      end
      #1;
   endtask

   task automatic idle();
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1);
   endtask

   task automatic issueOne(input logic [4:0] an);
      applyStimulus(1, an, 0, 0, 0, 0, 0, 0, 1);
   endtask

   task automatic cdbOne(input logic [2:0] ct, input logic [31:0] cd);
      applyStimulus(0, 0, 1, ct, cd, ct, 3'(ct + 1), 0, 1);
   endtask

   initial begin
      int  issuePct;
      int  cdbPct;
      bit  ir;
      bit  cv;
      bit  fl;
      bit  rn;
      logic [2:0] ct;

      reset_n        = 1'b0;
      issue_req      = 1'b0;
      issue_arch_num = '0;
      cdb_valid      = 1'b0;
      cdb_tag        = '0;
      cdb_data       = '0;
      read_tag       = '0;
      flush          = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      idle();

      // Out-of-order completion, in-order retirement.
      issueOne(5'd1);
      issueOne(5'd2);
      issueOne(5'd3);
      cdbOne(3'd1, 32'h11);
      cdbOne(3'd0, 32'h10);
      cdbOne(3'd2, 32'h12);
      repeat (3) idle();

      // Fill completely, refused ninth issue, then drain one.
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 1);
      for (int i = 0; i < 9; i++) issueOne(5'(i + 4));
      cdbOne(3'd0, 32'hA0);
      issueOne(5'd20);
      issueOne(5'd21);

      // Same-cycle bypass on a not-yet-done entry, then no broadcast.
      applyStimulus(0, 0, 1, 3'd4, 32'hABCD, 3'd4, 3'd5, 0, 1);
      applyStimulus(0, 0, 0, 0, 0, 3'd5, 3'd6, 0, 1);

      // Flush with a retiring head, then a late broadcast.
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 1);
      for (int i = 0; i < 3; i++) issueOne(5'(i + 1));
      cdbOne(3'd0, 32'h55);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 1);
      cdbOne(3'd1, 32'h66);
      repeat (2) idle();

      // Random traffic in phases of differing issue/complete pressure.
      for (int phase = 0; phase < 4; phase++) begin
         issuePct = (phase == 0) ? 90 : (phase == 1) ? 30 : 60;
         cdbPct   = (phase == 0) ? 20 : (phase == 1) ? 90 : 60;
         for (int c = 0; c < 500; c++) begin
            ir = ($urandom_range(0, 99) < issuePct);
            cv = ($urandom_range(0, 99) < cdbPct);
            fl = ($urandom_range(0, 99) < 2);
            rn = !($urandom_range(0, 199) == 0);
            if (rob.size() > 0 && $urandom_range(0, 3) != 0)
               ct = rob[$urandom_range(0, rob.size() - 1)].tag;
            else
               ct = 3'($urandom_range(0, 7));
            applyStimulus(ir, 5'($urandom), cv, ct, $urandom,
                          3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                          fl, rn);
         end
      end

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
